shift_add_multiplier_4_bit: RTL

Sequential 4x4 unsigned shift-and-add multiplier. It sits directly downstream of the 4-bit ripple adder: it instantiates one `ripple_addr_4_bit` as its only arithmetic resource and reuses it over four iterations to form an 8-bit product. It is the first multi-cycle arithmetic block in the arithmetic collection and uses a simple start/busy/done handshake for the requesting logic.

---
 rtl/shift_add_multiplier_4_bit.sv | 111 +++++++++++
 1 files changed

// File: rtl/shift_add_multiplier_4_bit.sv
// 4x4 unsigned sequential shift-and-add multiplier.
// One 4-bit ripple adder is reused over four iterations. Each iteration adds
// the multiplicand into the upper half when the current multiplier bit is 1.
// The {P,Q} pair is then shifted right, with the adder carry entering at the top.

module ripple_addr_4_bit (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       C_in,
  output logic [3:0] Z,
  output logic       C_out
);
  logic [4:0] w_c;

  assign w_c[0] = C_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign Z[i]     = X[i] ^ Y[i] ^ w_c[i];
    assign w_c[i+1] = (X[i] & Y[i]) | (w_c[i] & (X[i] ^ Y[i]));
  end

  assign C_out = w_c[4];
endmodule

module shift_add_multiplier_4_bit (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic [7:0] Z,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_a, r_p, r_q;
  logic [1:0]  r_cnt;
  logic [7:0]  r_z;
  logic [3:0]  w_addend, w_sum;
  logic        w_c;
  logic        w_last;

  // The addend is gated by the low multiplier bit, which is the bit being retired.
  assign w_addend = r_q[0] ? r_a : 4'b0000;
  assign w_last   = (r_cnt == 2'd3);

  ripple_addr_4_bit u_add (
    .X     (r_p),
    .Y     (w_addend),
    .C_in  (1'b0),
    .Z     (w_sum),
    .C_out (w_c)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic. Start is only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture and add-then-shift iteration.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_a   <= 4'h0;
      r_p   <= 4'h0;
      r_q   <= 4'h0;
      r_cnt <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a   <= X;
          r_q   <= Y;
          r_p   <= 4'h0;
          r_cnt <= 2'd0;
        end
        S_CALC: begin
          {r_p, r_q} <= {w_c, w_sum, r_q[3:1]};
          r_cnt      <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // The result register updates only on the final iteration, so it holds between operations.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          r_z <= 8'h00;
    else if (r_state == S_CALC && w_last) r_z <= {w_c, w_sum, r_q[3:1]};
  end

  assign Z    = r_z;
  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_DONE);
endmodule
